uart_tx_core: RTL and testbench

UART transmitter that serialises one parallel word per request into a standard 8N1-style frame: 1 start bit, DATA_WIDTH data bits LSB first, and 1 stop bit. It sits beside the UART receiver in the UART subsystem and shares its parameter set, so both ends agree on baud rate and word size. All logic runs on clk. Bit timing comes from a clock-enable tick, not a derived clock.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_baud_gen.sv | 42 ++++
 rtl/uart_tx_core.sv | 111 +++++++++++
 tb/tb_uart_tx_core.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and bit-timing helper,
// common to the transmitter and the receiver.
package uart_pkg;

    // Encoding is shared with the receiver, so keep the values fixed
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } uart_state_e;

    // clk cycles per serial bit (integer division, truncating)
    function automatic int unsigned calc_bit_count(input int unsigned clk_freq_mhz,
                                                   input int unsigned baudrate);
        return (clk_freq_mhz * 1_000_000) / baudrate;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Baud tick generator: one-cycle tick every BIT_COUNT enabled clk cycles.
// Counter holds at zero while disabled and restarts on clr.
module uart_baud_gen #(
    parameter int unsigned BIT_COUNT = 10
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int unsigned CW = (BIT_COUNT > 1) ? $clog2(BIT_COUNT) : 1;
    localparam logic [CW-1:0] LAST = CW'(BIT_COUNT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: wrap at LAST, forced to zero on clear or when disabled
    always_comb begin
        cnt_d = cnt_q;
        if (clr || !en) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en && !clr && (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_core.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, stop bit.
// FSM, shift register and bit counter live here; bit timing comes from
// uart_baud_gen as a clock-enable tick.
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned BAUDRATE     = 9600,
    parameter int unsigned CLK_FREQ_MHZ = 125,
    parameter int unsigned BIT_COUNT    = calc_bit_count(CLK_FREQ_MHZ, BAUDRATE)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  tx_start,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  tx,
    output logic                  tx_busy,
    output logic                  tx_done
);

    localparam int unsigned BW = $clog2(DATA_WIDTH + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    if (BIT_COUNT < 2) begin : g_bit_count_check
        $error("uart_tx_core: BIT_COUNT must be at least 2");
    end

    uart_state_e           state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic                  tx_q, tx_d;
    logic                  done_q, done_d;
    logic                  accept;
    logic                  bit_tick;

    uart_baud_gen #(
        .BIT_COUNT(BIT_COUNT)
    ) u_baud_gen (
        .clk (clk),
        .rstn(rstn),
        .clr (accept),
        .en  (state_q != IDLE),
        .tick(bit_tick)
    );

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        done_d    = 1'b0;
        accept    = 1'b0;
        case (state_q)
            IDLE: begin
                if (tx_start) begin
                    accept    = 1'b1;
                    shift_d   = data_i;
                    bit_cnt_d = '0;
                    state_d   = START;
                end
            end
            START: begin
                if (bit_tick) state_d = DATA;
            end
            DATA: begin
                if (bit_tick) begin
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + BW'(1);
                    if (bit_cnt_q == LAST_BIT) state_d = STOP;
                end
            end
            STOP: begin
                if (bit_tick) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // tx is decoded from the next state so the flop shows the new bit
        // on the same edge the state changes
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    // State, datapath and output registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            done_q    <= done_d;
        end
    end

    assign tx      = tx_q;
    assign tx_busy = (state_q != IDLE);
    assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_core.sv
// Self-checking bench for uart_tx_core at BIT_COUNT=10, DATA_WIDTH=8.
// Expected line waveform is computed from the frame bit layout.
module tb_uart_tx_core;

    localparam int BC = 10;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       tx_start = 1'b0;
    logic [7:0] data_i = '0;
    logic       tx;
    logic       tx_busy;
    logic       tx_done;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    uart_tx_core #(
        .DATA_WIDTH  (8),
        .BAUDRATE    (100000),
        .CLK_FREQ_MHZ(1)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .tx_start(tx_start),
        .data_i  (data_i),
        .tx      (tx),
        .tx_busy (tx_busy),
        .tx_done (tx_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Send one frame and check it cycle by cycle.
    // pre: tx_start already high from a previous frame; hold: keep it high.
    // ign_at: frame cycle at which to pulse an (ignored) request.
    task automatic send(input string tag, input logic [7:0] d, input bit pre, input bit hold,
                        input int ign_at, input logic [7:0] ign_d, input logic [7:0] nxt,
                        output int done_cyc);
        int         werr = 0;
        int         berr = 0;
        int         derr = 0;
        logic [9:0] frame;
        logic [7:0] rx = '0;
        frame = {1'b1, d, 1'b0};
        if (!pre) begin
            @(negedge clk);
            tx_start = 1'b1;
            data_i   = d;
        end
        @(posedge clk);
        #1;
        if (!hold) tx_start = 1'b0;
        data_i = hold ? nxt : 8'($urandom);
        for (int k = 0; k < 10 * BC; k++) begin
            @(negedge clk);
            if (tx !== frame[k / BC]) werr++;
            if (tx_busy !== 1'b1) berr++;
            if (tx_done !== 1'b0) derr++;
            if ((k % BC) == BC / 2 && (k / BC) >= 1 && (k / BC) <= 8) rx[k / BC - 1] = tx;
            if (k == ign_at) begin
                tx_start = 1'b1;
                data_i   = ign_d;
            end
            if (k == ign_at + 1) tx_start = 1'b0;
        end
        chk({tag, " waveform errs"}, werr, 0);
        chk({tag, " busy errs"}, berr, 0);
        chk({tag, " early done"}, derr, 0);
        chk({tag, " rx word"}, rx, d);
        @(negedge clk);
        done_cyc = cyc;
        chk({tag, " done pulse"}, tx_done, 1);
        chk({tag, " busy end"}, tx_busy, 0);
        chk({tag, " gap tx"}, tx, 1);
    endtask

    // Line must stay idle for n cycles
    task automatic quiet(input string tag, input int n);
        int err = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) err++;
        end
        chk({tag, " idle errs"}, err, 0);
    endtask

    initial begin
        int c1, c2;
        logic [7:0] w;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset tx", tx, 1);
        chk("reset busy", tx_busy, 0);
        chk("reset done", tx_done, 0);
        rstn = 1'b1;
        quiet("post reset", 5);

        // Single frame
        send("A5", 8'hA5, 0, 0, 1000, 8'h00, 8'h00, c1);
        quiet("A5 after", 20);

        // Request during a frame is dropped
        send("3C", 8'h3C, 0, 0, 40, 8'hFF, 8'h00, c1);
        quiet("3C no second frame", 150);

        // Back-to-back with tx_start held high; also all-zero/all-one data
        send("b2b 00", 8'h00, 0, 1, 1000, 8'h00, 8'hFF, c1);
        send("b2b FF", 8'hFF, 1, 0, 1000, 8'h00, 8'h00, c2);
        chk("b2b done spacing", c2 - c1, 101);
        quiet("b2b after", 20);

        // Reset in the middle of a frame
        @(negedge clk);
        tx_start = 1'b1;
        data_i   = 8'h55;
        @(posedge clk);
        #1;
        tx_start = 1'b0;
        repeat (35) @(negedge clk);
        chk("mid busy before", tx_busy, 1);
        rstn = 1'b0;
        #1;
        chk("mid reset tx", tx, 1);
        chk("mid reset busy", tx_busy, 0);
        repeat (3) @(negedge clk);
        chk("mid reset done", tx_done, 0);
        rstn = 1'b1;
        quiet("mid after release", 10);
        send("81", 8'h81, 0, 0, 1000, 8'h00, 8'h00, c1);

        // Reset wins over a simultaneous request
        @(negedge clk);
        tx_start = 1'b1;
        rstn     = 1'b0;
        @(posedge clk);
        #1;
        chk("rst wins busy", tx_busy, 0);
        chk("rst wins tx", tx, 1);
        @(negedge clk);
        tx_start = 1'b0;
        rstn     = 1'b1;
        quiet("rst wins after", 5);

        // Random words decoded by the bench-side receiver
        for (int i = 0; i < 16; i++) begin
            w = 8'($urandom);
            send($sformatf("rand%0d", i), w, 0, 0, 1000, 8'h00, 8'h00, c1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
